// File: rtl/k_in_a_row_ctrl.sv
// k_in_a_row_ctrl: two-player K-in-a-row game controller on an N x N board.
// Moves are validated and written in one cycle, then a single CHECK cycle
// scans every line of K cells for the mover's code. The outcome is a win,
// a draw, or a hand-over of the turn to the other player.
//
// Handshake: move_req is a strobe sampled on every rising edge (there is no
// ready). Each sampled move_req gets exactly one response pulse one cycle
// later: move_ack if the move was applied, or move_err if it was rejected.
// The exception is a cycle that also has new_game or reset; such a move gets
// no response at all.
module k_in_a_row_ctrl #(
    parameter int N        = 3,
    parameter int K        = 3,
    parameter int P1_FIRST = 1,
    localparam int PW      = $clog2(N*N),
    localparam int CW      = $clog2(N*N+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic              move_req,
    input  logic              move_player,
    input  logic [PW-1:0]     move_pos,
    output logic              move_ack,
    output logic              move_err,
    output logic [2*N*N-1:0]  board,
    output logic [2:0]        led_p1,
    output logic [2:0]        led_p2,
    output logic              busy,
    output logic [2:0]        state_dbg,
    output logic [CW-1:0]     move_cnt
);

    localparam int CELLS = N*N;

    typedef enum logic [2:0] {
        TURN_P1 = 3'd0,
        TURN_P2 = 3'd1,
        CHECK   = 3'd2,
        WIN_P1  = 3'd3,
        WIN_P2  = 3'd4,
        DRAW    = 3'd5
    } state_t;

    localparam state_t FIRST = (P1_FIRST != 0) ? TURN_P1 : TURN_P2;

    state_t              state_q, state_d;
    logic [2*N*N-1:0]    board_q, board_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mover_q, mover_d;   // 0 = player 1 made the last move
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [2:0]          led1_q, led2_q;
    logic                busy_q;

    logic                cell_empty;
    logic                accept;
    logic [1:0]          mover_code;
    logic [1:0]          req_code;
    logic                win;
    logic                line_ok;

    // Status LEDs for one player: bit0 = its turn, bit1 = it won, bit2 = draw.
    function automatic logic [2:0] led_of(input state_t s, input logic p2);
        logic [2:0] l;
        l[0] = p2 ? (s == TURN_P2) : (s == TURN_P1);
        l[1] = p2 ? (s == WIN_P2)  : (s == WIN_P1);
        l[2] = (s == DRAW);
        return l;
    endfunction

    assign mover_code = mover_q     ? 2'b10 : 2'b01;
    assign req_code   = move_player ? 2'b10 : 2'b01;

    // Occupancy of the requested cell; out-of-range indices read as not empty.
    always_comb begin
        cell_empty = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (int'(move_pos) == i) cell_empty = (board_q[2*i +: 2] == 2'b00);
        end
    end

    assign accept = move_req && cell_empty &&
                    (((state_q == TURN_P1) && !move_player) ||
                     ((state_q == TURN_P2) &&  move_player));

    // Scan every K-long horizontal, vertical, diagonal and anti-diagonal run.
    // The loop bounds keep every run inside one row/column, so nothing wraps.
    always_comb begin
        win     = 1'b0;
        line_ok = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c <= N-K; c++) begin
                line_ok = 1'b1;
                for (int k = 0; k < K; k++)
                    if (board_q[2*(r*N + c + k) +: 2] != mover_code) line_ok = 1'b0;
                if (line_ok) win = 1'b1;
            end
        end
        for (int r = 0; r <= N-K; r++) begin
            for (int c = 0; c < N; c++) begin
                line_ok = 1'b1;
                for (int k = 0; k < K; k++)
                    if (board_q[2*((r + k)*N + c) +: 2] != mover_code) line_ok = 1'b0;
                if (line_ok) win = 1'b1;
            end
        end
        for (int r = 0; r <= N-K; r++) begin
            for (int c = 0; c <= N-K; c++) begin
                line_ok = 1'b1;
                for (int k = 0; k < K; k++)
                    if (board_q[2*((r + k)*N + c + k) +: 2] != mover_code) line_ok = 1'b0;
                if (line_ok) win = 1'b1;
            end
        end
        for (int r = 0; r <= N-K; r++) begin
            for (int c = K-1; c < N; c++) begin
                line_ok = 1'b1;
                for (int k = 0; k < K; k++)
                    if (board_q[2*((r + k)*N + c - k) +: 2] != mover_code) line_ok = 1'b0;
                if (line_ok) win = 1'b1;
            end
        end
    end

    // Next-state logic: new_game dominates, then the per-state move handling.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        cnt_d   = cnt_q;
        mover_d = mover_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (new_game) begin
            board_d = '0;
            cnt_d   = '0;
            state_d = FIRST;
        end else begin
            case (state_q)
                TURN_P1, TURN_P2: begin
                    if (accept) begin
                        for (int i = 0; i < CELLS; i++)
                            if (int'(move_pos) == i) board_d[2*i +: 2] = req_code;
                        cnt_d   = cnt_q + CW'(1);
                        mover_d = move_player;
                        ack_d   = 1'b1;
                        state_d = CHECK;
                    end else if (move_req) begin
                        err_d = 1'b1;
                    end
                end
                CHECK: begin
                    err_d = move_req;
                    if (win)                        state_d = mover_q ? WIN_P2 : WIN_P1;
                    else if (cnt_q == CW'(CELLS))   state_d = DRAW;
                    else                            state_d = mover_q ? TURN_P1 : TURN_P2;
                end
                default: begin
                    err_d = move_req;
                end
            endcase
        end
    end

    // State and registered outputs; reset overrides everything, mid-CHECK too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FIRST;
            board_q <= '0;
            cnt_q   <= '0;
            mover_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            led1_q  <= led_of(FIRST, 1'b0);
            led2_q  <= led_of(FIRST, 1'b1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            cnt_q   <= cnt_d;
            mover_q <= mover_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            led1_q  <= led_of(state_d, 1'b0);
            led2_q  <= led_of(state_d, 1'b1);
            busy_q  <= (state_d == CHECK);
        end
    end

    assign move_ack  = ack_q;
    assign move_err  = err_q;
    assign board     = board_q;
    assign led_p1    = led1_q;
    assign led_p2    = led2_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
    assign move_cnt  = cnt_q;

endmodule

// File: tb/tb_k_in_a_row_ctrl.sv
// Bench for k_in_a_row_ctrl: instance A is N=3,K=3 and instance B is
// N=5,K=4. A table of moves drives both instances, and extra hand-written
// sequences cover the board contents, draw, new_game collisions and reset
// during CHECK.
module tb_k_in_a_row_ctrl;

    localparam int ST_TP1 = 0, ST_TP2 = 1, ST_CHK = 2, ST_W1 = 3, ST_W2 = 4, ST_DRAW = 5;

    // Clock and reset stimulus
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset = 1'b1, a_new_game = 1'b0, a_move_req = 1'b0, a_move_player = 1'b0;
    logic [3:0] a_move_pos = '0;
    logic       a_move_ack, a_move_err, a_busy;
    logic [17:0] a_board;
    logic [2:0] a_led_p1, a_led_p2, a_state;
    logic [3:0] a_cnt;

    logic       b_reset = 1'b1, b_new_game = 1'b0, b_move_req = 1'b0, b_move_player = 1'b0;
    logic [4:0] b_move_pos = '0;
    logic       b_move_ack, b_move_err, b_busy;
    logic [49:0] b_board;
    logic [2:0] b_led_p1, b_led_p2, b_state;
    logic [4:0] b_cnt;

    k_in_a_row_ctrl #(.N(3), .K(3), .P1_FIRST(1)) dut_a (
        .clk(clk), .reset(a_reset), .new_game(a_new_game), .move_req(a_move_req),
        .move_player(a_move_player), .move_pos(a_move_pos), .move_ack(a_move_ack),
        .move_err(a_move_err), .board(a_board), .led_p1(a_led_p1), .led_p2(a_led_p2),
        .busy(a_busy), .state_dbg(a_state), .move_cnt(a_cnt)
    );

    k_in_a_row_ctrl #(.N(5), .K(4), .P1_FIRST(1)) dut_b (
        .clk(clk), .reset(b_reset), .new_game(b_new_game), .move_req(b_move_req),
        .move_player(b_move_player), .move_pos(b_move_pos), .move_ack(b_move_ack),
        .move_err(b_move_err), .board(b_board), .led_p1(b_led_p1), .led_p2(b_led_p2),
        .busy(b_busy), .state_dbg(b_state), .move_cnt(b_cnt)
    );

    // One table record: op 0 = move, op 1 = reset of the selected instance
    typedef struct {
        int op;
        int sel;
        bit pl;
        int pos;
        bit ea;
        bit ee;
        int st;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] get_ackerr(input int sel);
        return (sel == 0) ? 64'({a_move_ack, a_move_err}) : 64'({b_move_ack, b_move_err});
    endfunction
    function automatic logic [63:0] get_state(input int sel);
        return (sel == 0) ? 64'(a_state) : 64'(b_state);
    endfunction
    function automatic logic [63:0] get_busy(input int sel);
        return (sel == 0) ? 64'(a_busy) : 64'(b_busy);
    endfunction
    function automatic logic [63:0] get_board(input int sel);
        return (sel == 0) ? 64'(a_board) : 64'(b_board);
    endfunction
    function automatic logic [63:0] get_leds(input int sel);
        return (sel == 0) ? 64'({a_led_p1, a_led_p2}) : 64'({b_led_p1, b_led_p2});
    endfunction
    function automatic logic [63:0] get_cnt(input int sel);
        return (sel == 0) ? 64'(a_cnt) : 64'(b_cnt);
    endfunction

    // Driver tasks
    task automatic set_in(input int sel, input logic rst, input logic ng, input logic req,
                          input logic pl, input int pos);
        if (sel == 0) begin
            a_reset = rst; a_new_game = ng; a_move_req = req; a_move_player = pl;
            a_move_pos = 4'(pos);
        end else begin
            b_reset = rst; b_new_game = ng; b_move_req = req; b_move_player = pl;
            b_move_pos = 5'(pos);
        end
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        set_in(sel, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rst_state", get_state(sel), ST_TP1);
        check("rst_board", get_board(sel), 64'd0);
        check("rst_cnt", get_cnt(sel), 64'd0);
        check("rst_leds", get_leds(sel), 64'({3'b001, 3'b000}));
        check("rst_ackerr", get_ackerr(sel), 64'd0);
        check("rst_busy", get_busy(sel), 64'd0);
    endtask

    task automatic do_move(input vec_t v);
        @(negedge clk);
        set_in(v.sel, 1'b0, 1'b0, 1'b1, v.pl, v.pos);
        exp_q.push_back({v.ea, v.ee});
        @(negedge clk);
        set_in(v.sel, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("ack_err", get_ackerr(v.sel), 64'(exp_q.pop_front()));
        if (v.ea) begin
            check("busy_in_check", get_busy(v.sel), 64'd1);
            check("state_check", get_state(v.sel), ST_CHK);
            @(negedge clk);
            check("busy_after", get_busy(v.sel), 64'd0);
            check("ack_err_idle", get_ackerr(v.sel), 64'd0);
        end
        check("state", get_state(v.sel), 64'(v.st));
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].op == 1) do_reset(vecs[i].sel);
            else                 do_move(vecs[i]);
        end
    endtask

    task automatic add_rst(input int sel);
        vec_t v;
        v.op = 1; v.sel = sel; v.pl = 1'b0; v.pos = 0; v.ea = 1'b0; v.ee = 1'b0; v.st = ST_TP1;
        vecs.push_back(v);
    endtask

    task automatic add_mv(input int sel, input int pl, input int pos, input int ea,
                          input int ee, input int st);
        vec_t v;
        v.op = 0; v.sel = sel; v.pl = bit'(pl); v.pos = pos; v.ea = bit'(ea); v.ee = bit'(ee);
        v.st = st;
        vecs.push_back(v);
    endtask

    int seg_a, seg_b, seg_c, seg_w, seg_d;

    initial begin
        // Row-0 win for player 1, then a move into the frozen board
        add_rst(0);
        add_mv(0, 0, 0, 1, 0, ST_TP2);
        add_mv(0, 1, 3, 1, 0, ST_TP1);
        add_mv(0, 0, 1, 1, 0, ST_TP2);
        add_mv(0, 1, 4, 1, 0, ST_TP1);
        add_mv(0, 0, 2, 1, 0, ST_W1);
        add_mv(0, 1, 5, 0, 1, ST_W1);
        seg_a = vecs.size();
        // Rejections: wrong player, occupied cell, out-of-range index
        add_rst(0);
        add_mv(0, 0, 4, 1, 0, ST_TP2);
        add_mv(0, 0, 5, 0, 1, ST_TP2);
        add_mv(0, 1, 4, 0, 1, ST_TP2);
        add_mv(0, 1, 9, 0, 1, ST_TP2);
        seg_b = vecs.size();
        // Full board with no line
        add_rst(0);
        add_mv(0, 0, 0, 1, 0, ST_TP2);
        add_mv(0, 1, 1, 1, 0, ST_TP1);
        add_mv(0, 0, 2, 1, 0, ST_TP2);
        add_mv(0, 1, 4, 1, 0, ST_TP1);
        add_mv(0, 0, 3, 1, 0, ST_TP2);
        add_mv(0, 1, 5, 1, 0, ST_TP1);
        add_mv(0, 0, 7, 1, 0, ST_TP2);
        add_mv(0, 1, 6, 1, 0, ST_TP1);
        add_mv(0, 0, 8, 1, 0, ST_DRAW);
        add_mv(0, 1, 0, 0, 1, ST_DRAW);
        seg_c = vecs.size();
        // Ninth move completes a diagonal: win beats draw
        add_rst(0);
        add_mv(0, 0, 0, 1, 0, ST_TP2);
        add_mv(0, 1, 2, 1, 0, ST_TP1);
        add_mv(0, 0, 1, 1, 0, ST_TP2);
        add_mv(0, 1, 3, 1, 0, ST_TP1);
        add_mv(0, 0, 4, 1, 0, ST_TP2);
        add_mv(0, 1, 6, 1, 0, ST_TP1);
        add_mv(0, 0, 5, 1, 0, ST_TP2);
        add_mv(0, 1, 7, 1, 0, ST_TP1);
        add_mv(0, 0, 8, 1, 0, ST_W1);
        seg_w = vecs.size();
        // N=5,K=4: anti-diagonal win, then row-edge non-win
        add_rst(1);
        add_mv(1, 0, 4, 1, 0, ST_TP2);
        add_mv(1, 1, 0, 1, 0, ST_TP1);
        add_mv(1, 0, 8, 1, 0, ST_TP2);
        add_mv(1, 1, 1, 1, 0, ST_TP1);
        add_mv(1, 0, 12, 1, 0, ST_TP2);
        add_mv(1, 1, 2, 1, 0, ST_TP1);
        add_mv(1, 0, 16, 1, 0, ST_W1);
        add_mv(1, 1, 3, 0, 1, ST_W1);
        add_rst(1);
        add_mv(1, 0, 3, 1, 0, ST_TP2);
        add_mv(1, 1, 10, 1, 0, ST_TP1);
        add_mv(1, 0, 4, 1, 0, ST_TP2);
        add_mv(1, 1, 11, 1, 0, ST_TP1);
        add_mv(1, 0, 5, 1, 0, ST_TP2);
        add_mv(1, 1, 12, 1, 0, ST_TP1);
        add_mv(1, 0, 6, 1, 0, ST_TP2);
        add_mv(1, 1, 25, 0, 1, ST_TP2);
        seg_d = vecs.size();

        run(0, seg_a);
        check("win_board_low", 64'(a_board[5:0]), 64'(6'b010101));
        check("win_board", get_board(0), 64'h295);
        check("win_leds", get_leds(0), 64'({3'b010, 3'b000}));
        check("win_cnt", get_cnt(0), 64'd5);

        run(seg_a, seg_b);
        check("err_board", get_board(0), 64'h100);
        check("err_leds", get_leds(0), 64'({3'b000, 3'b001}));
        check("err_cnt", get_cnt(0), 64'd1);

        run(seg_b, seg_c);
        check("draw_leds", get_leds(0), 64'({3'b100, 3'b100}));
        check("draw_cnt", get_cnt(0), 64'd9);

        run(seg_c, seg_w);
        check("lastwin_leds", get_leds(0), 64'({3'b010, 3'b000}));
        check("lastwin_cnt", get_cnt(0), 64'd9);

        run(seg_w, seg_d);
        check("b_edge_leds", get_leds(1), 64'({3'b000, 3'b001}));
        check("b_edge_cnt", get_cnt(1), 64'd7);

        // new_game together with a legal move mid-game
        do_reset(0);
        begin
            vec_t v;
            v.op = 0; v.sel = 0; v.pl = 1'b0; v.pos = 0; v.ea = 1'b1; v.ee = 1'b0; v.st = ST_TP2;
            do_move(v);
            v.pl = 1'b1; v.pos = 4; v.st = ST_TP1;
            do_move(v);
        end
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        exp_q.push_back(2'b00);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("ng_ackerr", get_ackerr(0), 64'(exp_q.pop_front()));
        check("ng_board", get_board(0), 64'd0);
        check("ng_state", get_state(0), ST_TP1);
        check("ng_cnt", get_cnt(0), 64'd0);
        check("ng_leds", get_leds(0), 64'({3'b001, 3'b000}));

        // Reset arriving while the controller sits in CHECK
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("chk_busy", get_busy(0), 64'd1);
        check("chk_board", get_board(0), 64'h100);
        @(negedge clk);
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("rstchk_state", get_state(0), ST_TP1);
        check("rstchk_board", get_board(0), 64'd0);
        check("rstchk_cnt", get_cnt(0), 64'd0);
        check("rstchk_busy", get_busy(0), 64'd0);
        check("rstchk_ackerr", get_ackerr(0), 64'd0);
        check("rstchk_leds", get_leds(0), 64'({3'b001, 3'b000}));

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/k_in_a_row_ctrl.md
K_IN_A_ROW_CTRL -- requirements
Module: k_in_a_row_ctrl

Interface
REQ-001 SHALL have parameter N, default 3, board side length (legal 3..6).
REQ-002 SHALL have parameter K, default 3, pieces in a line needed to win (legal 3..N).
REQ-003 SHALL have parameter P1_FIRST, default 1, meaning player 1 moves first after reset or new game (0 = player 2 first).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port new_game  input  1  one-cycle request to clear the board and restart without reset.
REQ-007 SHALL have port move_req  input  1  move strobe, sampled each rising edge.
REQ-008 SHALL have port move_player  input  1  0 = player 1, 1 = player 2.
REQ-009 SHALL have port move_pos  input  PW=clog2(N*N)  cell index, row-major, 0 = top-left.
REQ-010 SHALL have port move_ack  output  1  one-cycle pulse, move accepted.
REQ-011 SHALL have port move_err  output  1  one-cycle pulse, move rejected.
REQ-012 SHALL have port board  output  2*N*N  cell i at bits [2i+1:2i]; 00 empty, 01 player 1, 10 player 2.
REQ-013 SHALL have ports led_p1, led_p2  output  3 each  bit0 = player's turn, bit1 = player won, bit2 = draw.
REQ-014 SHALL have port busy  output  1  high while in CHECK.

Function
REQ-015 SHALL implement FSM states TURN_P1, TURN_P2, CHECK, WIN_P1, WIN_P2, DRAW.
REQ-016 SHALL accept a move only in TURN_Px with move_req=1, move_player matching the turn, move_pos < N*N, and the target cell 00.
REQ-017 On acceptance SHALL write the cell, pulse move_ack the next cycle, increment the 0..N*N move counter, and enter CHECK.
REQ-018 Any other move_req (wrong player, out-of-range index, occupied cell, in CHECK/WIN/DRAW) SHALL pulse move_err the next cycle and change no state.
REQ-019 move_ack and move_err SHALL never be high together.
REQ-020 CHECK SHALL last exactly one cycle and evaluate every horizontal, vertical, diagonal and anti-diagonal run of K cells for the mover's code.
REQ-021 From CHECK: win -> WIN_Px; else move counter == N*N -> DRAW; else -> other player's TURN state.
REQ-022 Win SHALL take priority over draw when the last cell completes a line.
REQ-023 Latency: board updates at req edge +1; led/FSM result at req edge +2; the next move is accepted no earlier than req edge +2.
REQ-024 WIN_P1, WIN_P2 and DRAW SHALL hold until new_game or reset; board is frozen.
REQ-025 new_game SHALL clear board and counter and enter the first-mover TURN state on the next edge, from any state including CHECK.
REQ-026 new_game and move_req in the same cycle: new_game wins, move is ignored, and neither ack nor err pulses.
REQ-027 led_pX bit0 SHALL be high only in that player's TURN state; bit1 only in WIN_PX; bit2 in DRAW for both players.
REQ-028 Lines SHALL not wrap across row edges (cell N-1 and cell N are not adjacent).

Reset
REQ-029 On reset=1 at a rising edge: board = 0, counter = 0, FSM = TURN_P1 (TURN_P2 if P1_FIRST=0), move_ack = move_err = busy = 0.
REQ-030 Reset SHALL override new_game and move_req, including when asserted mid-CHECK.

Verification
REQ-031 N=3,K=3: P1 0, P2 3, P1 1, P2 4, P1 2 -> five acks, then led_p1=3'b010 and board[5:0]=6'b010101.
REQ-032 N=3: P1 plays 4, then P1 plays 5 -> second move move_err=1 and board unchanged; P2 plays 4 -> move_err=1; P2 plays 9 -> move_err=1.
REQ-033 N=3: full-board sequence with no line (0,1,2,4,3,5,7,6,8) -> led_p1=led_p2=3'b100 and counter = 9.
REQ-034 N=5,K=4: P1 anti-diagonal 4,8,12,16 interleaved with P2 0,1,2 -> WIN_P1; row-edge test: P1 3,4,5,6 (interleaved) must not win.
REQ-035 Mid-game, assert new_game together with move_req -> board=0, no ack/err, first-mover TURN next cycle; then reset during CHECK -> REQ-029 values.
